// File: rtl/branch_predictor_pkg.sv
// rtl/branch_predictor_pkg.sv - shared constants, queue entry type and counter helper
//
// Purpose: opcode and counter constants used by the predictor, the layout of
// an outstanding-prediction queue entry, and the saturating counter update.
// Ports: none (package).

package branch_predictor_pkg;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [1:0] CNT_WNT = 2'd1;
  localparam logic [1:0] CNT_MAX = 2'd3;

  // Entries carry the full word index of the PC (PC[31:2]) so the entry
  // layout does not depend on the table size chosen by the instantiating block.
  localparam int PC_IDX_W = 30;

  typedef struct packed {
    logic [PC_IDX_W-1:0] idx;
    logic                is_cond;
    logic                pred;
  } q_entry_t;

  // 2-bit saturating counter step: up on taken, down on not-taken, no wrap.
  function automatic logic [1:0] cnt_train(input logic [1:0] cnt, input logic taken);
    if (taken) begin
      return (cnt == CNT_MAX) ? CNT_MAX : cnt + 2'd1;
    end
    return (cnt == 2'd0) ? 2'd0 : cnt - 2'd1;
  endfunction

endpackage

// File: rtl/branch_predictor_pred_queue.sv
// rtl/branch_predictor_pred_queue.sv - in-order queue of outstanding predictions
//
// Purpose: synchronous FIFO of q_entry_t with a clear input and same-cycle
// push/pop. Pointers carry one extra wrap bit so full and empty are distinct.
// Ports:
//   clk_i, rst_i     clock, synchronous active-high reset
//   clr_i            drop every entry at this edge; overrides push and pop
//   push_i, entry_i  write entry_i at the tail
//   pop_i            advance the head (caller guarantees non-empty)
//   head_o           entry at the head, combinational
//   full_o, empty_o  occupancy flags

module pred_queue
  import branch_predictor_pkg::*;
#(
  parameter int QDEPTH = 4
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     clr_i,
  input  logic     push_i,
  input  q_entry_t entry_i,
  input  logic     pop_i,
  output q_entry_t head_o,
  output logic     full_o,
  output logic     empty_o
);

  localparam int AW = $clog2(QDEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  q_entry_t      mem_q [QDEPTH];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (clr_i) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (push_i) wr_d = wr_q + PW'(1);
      if (pop_i)  rd_d = rd_q + PW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // When full with a simultaneous pop, the tail slot is the head slot; the
  // head is read combinationally before this edge overwrites it.
  always_ff @(posedge clk_i) begin
    if (push_i && !clr_i && !rst_i) begin
      mem_q[wr_q[AW-1:0]] <= entry_i;
    end
  end

  assign head_o  = mem_q[rd_q[AW-1:0]];
  assign full_o  = (wr_q[AW-1:0] == rd_q[AW-1:0]) && (wr_q[AW] != rd_q[AW]);
  assign empty_o = (wr_q == rd_q);

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - 2-bit counter branch predictor with in-order resolution queue
//
// Purpose: classify fetched instructions, predict from a PC-indexed table of
// 2-bit saturating counters (JAL/JALR always taken), queue control-flow
// predictions, and on resolution train the table and flag mispredicts.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   f_valid, f_pc,    fetched instruction
//   f_instr
//   f_ready           combinational fetch accept
//   p_valid, p_taken  registered prediction for last cycle's accepted fetch
//   r_valid, r_taken  outcome of the oldest outstanding control instruction
//   mispredict        registered one-cycle pulse
//   r_err             sticky: resolution arrived with the queue empty

module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int IDX_BITS = 6,
  parameter int QDEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        f_valid,
  input  logic [31:0] f_pc,
  input  logic [31:0] f_instr,
  output logic        f_ready,
  output logic        p_valid,
  output logic        p_taken,
  input  logic        r_valid,
  input  logic        r_taken,
  output logic        mispredict,
  output logic        r_err
);

  localparam int NCNT = 1 << IDX_BITS;

  logic [1:0] cnt_q [NCNT];

  logic [6:0]          opcode;
  logic                is_cond, is_jump, is_ctrl;
  logic [IDX_BITS-1:0] f_idx, t_idx;
  logic                f_pred;
  logic                accept, push, pop;
  logic                q_full, q_empty;
  q_entry_t            push_entry, head;

  logic p_valid_q, p_valid_d;
  logic p_taken_q, p_taken_d;
  logic mispredict_q, mispredict_d;
  logic r_err_q, r_err_d;

  assign opcode  = f_instr[6:0];
  assign is_cond = (opcode == OP_BRANCH);
  assign is_jump = (opcode == OP_JAL) || (opcode == OP_JALR);
  assign is_ctrl = is_cond || is_jump;

  // Table read is the pre-update value even when the same cycle trains this index.
  assign f_idx  = f_pc[IDX_BITS+1:2];
  assign f_pred = is_cond ? cnt_q[f_idx][1] : is_jump;

  // An r_valid against an empty queue never pops, even if this cycle pushes.
  assign pop     = r_valid && !q_empty;
  assign f_ready = !q_full || pop;
  assign accept  = f_valid && f_ready;

  assign mispredict_d = pop && (r_taken != head.pred);
  // Pushes in the mispredicting cycle are wrong-path and dropped with the flush.
  assign push         = accept && is_ctrl && !mispredict_d;

  assign push_entry = '{idx: f_pc[31:2], is_cond: is_cond, pred: f_pred};

  assign p_valid_d = accept;
  assign p_taken_d = accept && f_pred;
  assign r_err_d   = r_err_q || (r_valid && q_empty);

  assign t_idx = head.idx[IDX_BITS-1:0];

  pred_queue #(
    .QDEPTH (QDEPTH)
  ) u_queue (
    .clk_i   (clk),
    .rst_i   (rst),
    .clr_i   (mispredict_d),
    .push_i  (push),
    .entry_i (push_entry),
    .pop_i   (pop),
    .head_o  (head),
    .full_o  (q_full),
    .empty_o (q_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCNT; i++) begin
        cnt_q[i] <= CNT_WNT;
      end
    end else if (pop && head.is_cond) begin
      cnt_q[t_idx] <= cnt_train(cnt_q[t_idx], r_taken);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_valid_q    <= 1'b0;
      p_taken_q    <= 1'b0;
      mispredict_q <= 1'b0;
      r_err_q      <= 1'b0;
    end else begin
      p_valid_q    <= p_valid_d;
      p_taken_q    <= p_taken_d;
      mispredict_q <= mispredict_d;
      r_err_q      <= r_err_d;
    end
  end

  assign p_valid    = p_valid_q;
  assign p_taken    = p_taken_q;
  assign mispredict = mispredict_q;
  assign r_err      = r_err_q;

  // Instruction bits above the opcode, PC byte offset and the entry's index
  // bits beyond the table size play no part in prediction.
  logic unused_bits;
  assign unused_bits = ^{f_instr[31:7], f_pc[1:0], head.idx[PC_IDX_W-1:IDX_BITS]};

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - self-checking bench for branch_predictor

module tb_branch_predictor;

  localparam int QDEPTH = 4;
  localparam int NCNT   = 64;
  localparam logic [31:0] I_BEQ  = 32'h0000_0063;
  localparam logic [31:0] I_JAL  = 32'h0000_006F;
  localparam logic [31:0] I_JALR = 32'h0000_0067;
  localparam logic [31:0] I_ADDI = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, f_valid, r_valid, r_taken;
  logic [31:0] f_pc, f_instr;
  logic        f_ready, p_valid, p_taken, mispredict, r_err;

  always #5 clk = ~clk;

  branch_predictor #(.IDX_BITS(6), .QDEPTH(QDEPTH)) dut (
    .clk(clk), .rst(rst), .f_valid(f_valid), .f_pc(f_pc), .f_instr(f_instr),
    .f_ready(f_ready), .p_valid(p_valid), .p_taken(p_taken),
    .r_valid(r_valid), .r_taken(r_taken), .mispredict(mispredict), .r_err(r_err)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: counter values as integers and a program-order list of
  // outstanding predictions.
  typedef struct { int idx; bit cond; bit pred; } ment_t;
  ment_t mq[$];
  int    mcnt [NCNT];
  bit    merr;

  bit   e_ready, e_pv, e_pt, e_mp, e_err;
  logic a_ready;

  task automatic model_reset();
    foreach (mcnt[i]) mcnt[i] = 1;
    mq.delete();
    merr = 1'b0;
  endtask

  task automatic do_reset(input bit busy);
    rst = 1'b1; f_valid = busy; f_pc = 32'h40; f_instr = I_BEQ; r_valid = busy; r_taken = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; f_valid = 1'b0; r_valid = 1'b0;
    model_reset();
  endtask

  // Drive one cycle, sample f_ready before the edge, advance the model, and
  // leave expected post-edge outputs in e_*.
  task automatic step(input bit fv, input logic [31:0] pc, input logic [31:0] instr,
                      input bit rv, input bit rt);
    int idx; logic [6:0] op; bit cond, ctrl, pred, popping, accept; ment_t h;
    f_valid = fv; f_pc = pc; f_instr = instr; r_valid = rv; r_taken = rt;
    #1;
    a_ready = f_ready;
    idx  = int'(pc[7:2]);
    op   = instr[6:0];
    cond = (op == 7'h63);
    ctrl = cond || (op == 7'h6F) || (op == 7'h67);
    pred = cond ? (mcnt[idx] >= 2) : ctrl;
    popping = rv && (mq.size() > 0);
    e_ready = (mq.size() < QDEPTH) || popping;
    accept  = fv && e_ready;
    e_mp = 1'b0;
    if (rv && mq.size() == 0) merr = 1'b1;
    if (popping) begin
      h = mq.pop_front();
      if (h.cond) begin
        if (rt) begin if (mcnt[h.idx] < 3) mcnt[h.idx]++; end
        else begin if (mcnt[h.idx] > 0) mcnt[h.idx]--; end
      end
      e_mp = (rt != h.pred);
    end
    if (e_mp) mq.delete();
    else if (accept && ctrl) mq.push_back('{idx, cond, pred});
    e_pv = accept; e_pt = accept && pred; e_err = merr;
    @(posedge clk); #1;
    f_valid = 1'b0; r_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(1'b0);
    tests++; if (p_valid !== 1'b0) begin fails++; $display("FAIL reset_p_valid: got %b want 0", p_valid); end
    tests++; if (p_taken !== 1'b0) begin fails++; $display("FAIL reset_p_taken: got %b want 0", p_taken); end
    tests++; if (mispredict !== 1'b0) begin fails++; $display("FAIL reset_mispredict: got %b want 0", mispredict); end
    tests++; if (r_err !== 1'b0) begin fails++; $display("FAIL reset_r_err: got %b want 0", r_err); end
    tests++; if (f_ready !== 1'b1) begin fails++; $display("FAIL reset_f_ready: got %b want 1", f_ready); end
  endtask

  task automatic test_predict_train();
    step(1, 32'h40, I_BEQ, 0, 0);
    tests++; if (p_valid !== 1'b1 || p_taken !== 1'b0) begin fails++; $display("FAIL basic_pred_wnt: got v=%b t=%b want v=1 t=0", p_valid, p_taken); end
    step(0, 32'h0, I_ADDI, 1, 1);
    tests++; if (mispredict !== 1'b1) begin fails++; $display("FAIL basic_mispredict: got %b want 1", mispredict); end
    step(1, 32'h40, I_BEQ, 0, 0);
    tests++; if (mispredict !== 1'b0) begin fails++; $display("FAIL basic_pulse_len: got %b want 0", mispredict); end
    tests++; if (p_taken !== 1'b1) begin fails++; $display("FAIL basic_pred_trained: got %b want 1", p_taken); end
    step(0, 32'h0, I_ADDI, 1, 1);
    tests++; if (mispredict !== 1'b0) begin fails++; $display("FAIL basic_correct: got %b want 0", mispredict); end
  endtask

  task automatic test_saturate();
    bit want_pred [3] = '{1'b0, 1'b1, 1'b1};
    bit want_mp   [3] = '{1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      step(1, 32'h80, I_BEQ, 0, 0);
      tests++; if (p_taken !== want_pred[i]) begin fails++; $display("FAIL sat_up_pred%0d: got %b want %b", i, p_taken, want_pred[i]); end
      step(0, 32'h0, I_ADDI, 1, 1);
      tests++; if (mispredict !== want_mp[i]) begin fails++; $display("FAIL sat_up_mp%0d: got %b want %b", i, mispredict, want_mp[i]); end
    end
    for (int i = 0; i < 2; i++) begin
      step(1, 32'h80, I_BEQ, 0, 0);
      tests++; if (p_taken !== 1'b1) begin fails++; $display("FAIL sat_dn_pred%0d: got %b want 1", i, p_taken); end
      step(0, 32'h0, I_ADDI, 1, 0);
      tests++; if (mispredict !== 1'b1) begin fails++; $display("FAIL sat_dn_mp%0d: got %b want 1", i, mispredict); end
    end
    step(1, 32'h80, I_BEQ, 0, 0);
    tests++; if (p_taken !== 1'b0) begin fails++; $display("FAIL sat_back_wnt: got %b want 0", p_taken); end
    step(0, 32'h0, I_ADDI, 1, 0);
    tests++; if (mispredict !== 1'b0) begin fails++; $display("FAIL sat_back_mp: got %b want 0", mispredict); end
  endtask

  task automatic test_jump();
    step(1, 32'hC0, I_JAL, 0, 0);
    tests++; if (p_taken !== 1'b1) begin fails++; $display("FAIL jal_pred: got %b want 1", p_taken); end
    step(1, 32'hC0, I_JALR, 0, 0);
    tests++; if (p_taken !== 1'b1) begin fails++; $display("FAIL jalr_pred: got %b want 1", p_taken); end
    for (int i = 0; i < 2; i++) begin
      step(0, 32'h0, I_ADDI, 1, 1);
      tests++; if (mispredict !== 1'b0) begin fails++; $display("FAIL jump_mp%0d: got %b want 0", i, mispredict); end
    end
    step(1, 32'hC0, I_BEQ, 0, 0);
    tests++; if (p_taken !== 1'b0) begin fails++; $display("FAIL jump_no_train: got %b want 0", p_taken); end
    step(0, 32'h0, I_ADDI, 1, 0);
    step(1, 32'h100, I_ADDI, 0, 0);
    tests++; if (p_valid !== 1'b1 || p_taken !== 1'b0) begin fails++; $display("FAIL nonctrl_pred: got v=%b t=%b want v=1 t=0", p_valid, p_taken); end
  endtask

  task automatic test_full();
    for (int i = 0; i < QDEPTH; i++) step(1, 32'h10 + 32'(4 * i), I_BEQ, 0, 0);
    step(1, 32'h34, I_BEQ, 0, 0);
    tests++; if (a_ready !== 1'b0) begin fails++; $display("FAIL full_ready: got %b want 0", a_ready); end
    tests++; if (p_valid !== 1'b0) begin fails++; $display("FAIL full_no_accept: got %b want 0", p_valid); end
    step(1, 32'h30, I_BEQ, 1, 0);
    tests++; if (a_ready !== 1'b1) begin fails++; $display("FAIL full_pushpop_ready: got %b want 1", a_ready); end
    tests++; if (p_valid !== 1'b1 || mispredict !== 1'b0) begin fails++; $display("FAIL full_pushpop: got v=%b mp=%b want v=1 mp=0", p_valid, mispredict); end
    step(0, 32'h0, I_ADDI, 0, 0);
    tests++; if (a_ready !== 1'b0) begin fails++; $display("FAIL full_count_kept: got %b want 0", a_ready); end
    for (int i = 0; i < QDEPTH; i++) begin
      step(0, 32'h0, I_ADDI, 1, 0);
      tests++; if (mispredict !== 1'b0) begin fails++; $display("FAIL full_drain%0d: got %b want 0", i, mispredict); end
    end
    tests++; if (r_err !== 1'b0) begin fails++; $display("FAIL full_drain_err: got %b want 0", r_err); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) step(1, 32'h20 + 32'(4 * i), I_BEQ, 0, 0);
    step(1, 32'h2C, I_BEQ, 1, 1);
    tests++; if (mispredict !== 1'b1) begin fails++; $display("FAIL flush_mp: got %b want 1", mispredict); end
    step(0, 32'h0, I_ADDI, 1, 0);
    tests++; if (r_err !== 1'b1) begin fails++; $display("FAIL flush_empty_err: got %b want 1", r_err); end
    tests++; if (mispredict !== 1'b0) begin fails++; $display("FAIL flush_empty_mp: got %b want 0", mispredict); end
  endtask

  task automatic test_reset_mid();
    step(1, 32'h40, I_BEQ, 0, 0);
    tests++; if (p_taken !== 1'b1) begin fails++; $display("FAIL mid_pre_trained: got %b want 1", p_taken); end
    step(1, 32'h44, I_JAL, 0, 0);
    do_reset(1'b1);
    tests++; if (r_err !== 1'b0 || mispredict !== 1'b0 || p_valid !== 1'b0 || p_taken !== 1'b0) begin
      fails++; $display("FAIL mid_outputs: got err=%b mp=%b v=%b t=%b want 0000", r_err, mispredict, p_valid, p_taken); end
    tests++; if (f_ready !== 1'b1) begin fails++; $display("FAIL mid_ready: got %b want 1", f_ready); end
    step(1, 32'h40, I_BEQ, 0, 0);
    tests++; if (p_taken !== 1'b0) begin fails++; $display("FAIL mid_cnt_reset: got %b want 0", p_taken); end
    step(0, 32'h0, I_ADDI, 1, 0);
    tests++; if (mispredict !== 1'b0 || r_err !== 1'b0) begin fails++; $display("FAIL mid_queue_discard: got mp=%b err=%b want 0 0", mispredict, r_err); end
  endtask

  task automatic test_random();
    logic [6:0]  nonctrl [4] = '{7'h13, 7'h33, 7'h03, 7'h37};
    logic [31:0] pc, instr;
    int sel;
    do_reset(1'b0);
    for (int n = 0; n < 600; n++) begin
      if (n == 300) do_reset(1'b1);
      sel = $urandom_range(0, 5);
      instr = $urandom & 32'hFFFF_FF80;
      case (sel)
        0, 1, 2: instr[6:0] = 7'h63;
        3:       instr[6:0] = 7'h6F;
        4:       instr[6:0] = 7'h67;
        default: instr[6:0] = nonctrl[$urandom_range(0, 3)];
      endcase
      pc = ($urandom & 32'hFFFF_FFE0) | 32'($urandom_range(0, 7) << 2) | 32'($urandom_range(0, 3));
      step($urandom_range(0, 9) < 6, pc, instr, $urandom_range(0, 9) < 4, 1'($urandom_range(0, 1)));
      tests++; if (a_ready !== e_ready) begin fails++; $display("FAIL rnd_ready@%0d: got %b want %b", n, a_ready, e_ready); end
      tests++; if (p_valid !== e_pv) begin fails++; $display("FAIL rnd_p_valid@%0d: got %b want %b", n, p_valid, e_pv); end
      if (e_pv) begin
        tests++; if (p_taken !== e_pt) begin fails++; $display("FAIL rnd_p_taken@%0d: got %b want %b", n, p_taken, e_pt); end
      end
      tests++; if (mispredict !== e_mp) begin fails++; $display("FAIL rnd_mispredict@%0d: got %b want %b", n, mispredict, e_mp); end
      tests++; if (r_err !== e_err) begin fails++; $display("FAIL rnd_r_err@%0d: got %b want %b", n, r_err, e_err); end
    end
  endtask

  initial begin
    rst = 1'b1; f_valid = 1'b0; r_valid = 1'b0; r_taken = 1'b0; f_pc = '0; f_instr = '0;
    model_reset();
    @(posedge clk); #1;
    test_reset();
    test_predict_train();
    test_saturate();
    test_jump();
    test_full();
    test_flush();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
